// File: rtl/cube_input.sv
// Button front end for the 4x4x4 life cube editor: sync + debounce per button, cursor/cell editing, load handshake.
// Optional macro CUBE_INPUT_WRAP_EN: coordinate increments wrap 3->0 instead of saturating at 3.
module cube_input #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnX,
  input  logic        BtnY,
  input  logic        BtnZ,
  input  logic        BtnToggle,
  input  logic        BtnClear,
  input  logic        BtnLoad,
  input  logic        LoadAck,
  output logic [63:0] Cells,
  output logic [5:0]  Cursor,
  output logic        LoadReq
);

  localparam int NBTN  = 6;
  localparam int CLOGW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_W = (CLOGW > 18) ? CLOGW : 18;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {EDIT, PENDING} state_t;

  logic [NBTN-1:0] w_btn_raw;
  logic [NBTN-1:0] w_press;

  // Bit order shared by w_btn_raw and w_press: X, Y, Z, Toggle, Clear, Load.
  assign w_btn_raw = {BtnLoad, BtnClear, BtnToggle, BtnZ, BtnY, BtnX};

  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      logic [1:0]       r_sync;
      logic [CNT_W-1:0] r_cnt;
      logic             r_db;
      logic             r_db_q;

      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_sync <= '0;
          r_cnt  <= '0;
          r_db   <= 1'b0;
          r_db_q <= 1'b0;
        end else begin
          r_sync <= {r_sync[0], w_btn_raw[gi]};
          r_db_q <= r_db;
          if (r_sync[1] != r_db) begin
            if (r_cnt >= CNT_LAST) begin
              r_db  <= r_sync[1];
              r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_press[gi] = r_db & ~r_db_q;
    end
  endgenerate

  function automatic logic [1:0] f_inc(input logic [1:0] c);
`ifdef CUBE_INPUT_WRAP_EN
    return c + 2'd1;
`else
    return (c == 2'd3) ? c : c + 2'd1;
`endif
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_cells;
  logic [63:0] w_cells_next;
  logic [5:0]  r_cursor;
  logic [5:0]  w_cursor_next;
  logic        r_load_req;
  logic        w_load_req_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= EDIT;
      r_cells    <= '0;
      r_cursor   <= '0;
      r_load_req <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cells    <= w_cells_next;
      r_cursor   <= w_cursor_next;
      r_load_req <= w_load_req_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cells_next    = r_cells;
    w_cursor_next   = r_cursor;
    w_load_req_next = r_load_req;
    case (r_state)
      EDIT: begin
        // Toggle addresses the pre-move cursor; moves land in w_cursor_next only.
        if (w_press[4])
          w_cells_next = '0;
        else if (w_press[3])
          w_cells_next = r_cells ^ (64'd1 << r_cursor);
        if (w_press[0]) w_cursor_next[1:0] = f_inc(r_cursor[1:0]);
        if (w_press[1]) w_cursor_next[3:2] = f_inc(r_cursor[3:2]);
        if (w_press[2]) w_cursor_next[5:4] = f_inc(r_cursor[5:4]);
        if (w_press[5]) begin
          w_load_req_next = 1'b1;
          w_state_next    = PENDING;
        end
      end
      PENDING: begin
        if (LoadAck) begin
          w_load_req_next = 1'b0;
          w_state_next    = EDIT;
        end
      end
      default: w_state_next = EDIT;
    endcase
  end

  assign Cells   = r_cells;
  assign Cursor  = r_cursor;
  assign LoadReq = r_load_req;

endmodule

// File: tb/tb_cube_input.sv
// Directed bench for cube_input with a short debounce window; honours CUBE_INPUT_WRAP_EN for expectations.
module tb_cube_input;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        BtnX = 1'b0, BtnY = 1'b0, BtnZ = 1'b0;
  logic        BtnToggle = 1'b0, BtnClear = 1'b0, BtnLoad = 1'b0;
  logic        LoadAck = 1'b0;
  logic [63:0] Cells;
  logic [5:0]  Cursor;
  logic        LoadReq;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] MX = 6'd1, MY = 6'd2, MZ = 6'd4, MT = 6'd8, MC = 6'd16, ML = 6'd32;

  cube_input #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnX(BtnX), .BtnY(BtnY), .BtnZ(BtnZ),
    .BtnToggle(BtnToggle), .BtnClear(BtnClear), .BtnLoad(BtnLoad),
    .LoadAck(LoadAck),
    .Cells(Cells), .Cursor(Cursor), .LoadReq(LoadReq)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  btns;
    logic [63:0] cells;
    logic [5:0]  cur;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic set_btns(input logic [5:0] m);
    {BtnLoad, BtnClear, BtnToggle, BtnZ, BtnY, BtnX} = m;
  endtask

  task automatic press(input logic [5:0] m);
    set_btns(m);
    repeat (10) @(negedge Clk);
    set_btns(6'd0);
    repeat (10) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  logic [1:0] exp_x3;

  initial begin
`ifdef CUBE_INPUT_WRAP_EN
    exp_x3 = 2'd0;
`else
    exp_x3 = 2'd3;
`endif
    vecs[0] = '{MX,      64'd0,       6'd1};
    vecs[1] = '{MY,      64'd0,       6'd5};
    vecs[2] = '{MZ,      64'd0,       6'd21};
    vecs[3] = '{MT,      64'd1 << 21, 6'd21};
    vecs[4] = '{MT | MX, 64'd0,       6'd22};
    vecs[5] = '{MT,      64'd1 << 22, 6'd22};
    vecs[6] = '{MC | MT, 64'd0,       6'd22};
    vecs[7] = '{MT,      64'd1 << 22, 6'd22};
    vecs[8] = '{MC,      64'd0,       6'd22};

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_cells", Cells, 64'd0);
    chk("reset_cursor", {58'd0, Cursor}, 64'd0);
    chk("reset_loadreq", {63'd0, LoadReq}, 64'd0);

    // Bouncing X: 2-cycle pulses never satisfy the 4-cycle window.
    for (int c = 0; c < 20; c++) begin
      BtnX = ((c / 2) % 2) == 0;
      @(negedge Clk);
    end
    chk("bounce_no_step", {58'd0, Cursor}, 64'd0);
    BtnX = 1'b1;
    repeat (12) @(negedge Clk);
    BtnX = 1'b0;
    repeat (12) @(negedge Clk);
    chk("bounce_one_step", {58'd0, Cursor}, 64'd1);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      press(vecs[i].btns);
      chk($sformatf("vec%0d_cells", i), Cells, vecs[i].cells);
      chk($sformatf("vec%0d_cursor", i), {58'd0, Cursor}, {58'd0, vecs[i].cur});
    end

    do_reset();
    for (int i = 0; i < 4; i++) press(MX);
    chk("x_four_presses", {58'd0, Cursor}, {62'd0, exp_x3});

    // Load handshake.
    do_reset();
    press(MT);
    chk("load_pre_cells", Cells, 64'd1);
    LoadAck = 1'b1;
    @(negedge Clk);
    LoadAck = 1'b0;
    @(negedge Clk);
    chk("ack_in_edit_ignored", {63'd0, LoadReq}, 64'd0);
    press(ML);
    chk("load_req_high", {63'd0, LoadReq}, 64'd1);
    press(MT);
    press(MC);
    press(MX);
    chk("pending_cells_frozen", Cells, 64'd1);
    chk("pending_cursor_frozen", {58'd0, Cursor}, 64'd0);
    chk("pending_req_held", {63'd0, LoadReq}, 64'd1);
    LoadAck = 1'b1;
    @(posedge Clk);
    #1;
    chk("ack_drops_req", {63'd0, LoadReq}, 64'd0);
    @(negedge Clk);
    LoadAck = 1'b0;
    press(MT);
    chk("back_in_edit", Cells, 64'd0);

    // Reset while PENDING.
    do_reset();
    press(MX);
    press(MT);
    press(ML);
    chk("pre_reset_cells", Cells, 64'd2);
    chk("pre_reset_req", {63'd0, LoadReq}, 64'd1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_pend_req", {63'd0, LoadReq}, 64'd0);
    chk("rst_pend_cells", Cells, 64'd0);
    chk("rst_pend_cursor", {58'd0, Cursor}, 64'd0);
    @(negedge Clk);

    // Button held through reset gives exactly one press afterward.
    BtnX = 1'b1;
    repeat (5) @(negedge Clk);
    Reset = 1'b0;
    repeat (14) @(negedge Clk);
    BtnX = 1'b0;
    repeat (12) @(negedge Clk);
    chk("held_through_reset", {58'd0, Cursor}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
